pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Parametrised PLL supervisor for the iCE40 clocking path. It drives PLL RESETB, waits for lock with a timeout and automatic retry, and qualifies lock stability. It then releases NUM_DOMAINS downstream reset lines in a staged order, and re-sequences after a filtered loss of lock. It runs on the free-running oscillator clock, not a PLL output, so it operates while the PLL is unlocked.

Parameters:
NUM_DOMAINS, 2, number of staged domain reset outputs (>=1)
PLL_RESET_CYCLES, 16, cycles pll_resetb is held low per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 4096, cycles to wait for lock before a retry (>=1)
LOCK_STABLE_CYCLES, 256, consecutive locked cycles required before release (>=1)
STAGE_GAP_CYCLES, 16, cycles between successive domain releases (>=1)
LOSS_FILTER_CYCLES, 4, consecutive unlocked cycles that count as lock loss (>=1)
CNT_W, 8, width of the saturating event counters

Ports:
clk  in  1  free-running oscillator clock
reset  in  1  asynchronous, active-low reset
pll_lock  in  1  PLL LOCK, asynchronous to clk
force_relock  in  1  synchronous request to restart the sequence
pll_resetb  out  1  to PLL RESETB (0 = PLL held in reset)
domain_reset_n  out  NUM_DOMAINS  per-domain active-low reset; bit 0 is released first
all_ready  out  1  high when all domains are released and the sequencer is in RUN
retry_count  out  CNT_W  saturating count of lock-timeout retries
loss_count  out  CNT_W  saturating count of filtered lock losses
state  out  3  current FSM state, for debug

Behaviour:
- Reset (reset=0, async): pll_resetb=0, domain_reset_n=all 0, all_ready=0, counters=0, state=PLL_RST. Takes effect immediately, including mid-operation.
- pll_lock passes through a 2-flop synchroniser to give lock_s (2-cycle latency). All decisions use lock_s.
- All outputs are registered. Consumers re-synchronise domain_reset_n deassertion in their own clock domain.
- One shared cycle counter, sized by $clog2 of the largest cycle parameter. It is cleared on every state change.
- FSM encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- PLL_RST: pll_resetb=0. After PLL_RESET_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: pll_resetb=1.
  - lock_s=1: go to STABLE.
  - LOCK_TIMEOUT_CYCLES elapse without lock: go to PLL_RST; retry_count++ (saturating).
- STABLE:
  - lock_s=0 on any cycle: return to WAIT_LOCK with the timeout restarted; no count change.
  - LOCK_STABLE_CYCLES consecutive lock_s=1: go to RELEASE.
- RELEASE: let E0 be the edge entering RELEASE.
  - domain_reset_n[i] rises at E0 + i*STAGE_GAP_CYCLES.
  - At E0 + NUM_DOMAINS*STAGE_GAP_CYCLES: go to RUN; all_ready=1 on the same edge.
- Loss filter, active in RELEASE and RUN:
  - Counts consecutive lock_s=0 cycles; any lock_s=1 clears it.
  - On reaching LOSS_FILTER_CYCLES, on one edge: domain_reset_n=all 0, all_ready=0, pll_resetb=0, loss_count++ (saturating), go to PLL_RST.
  - Shorter glitches have no effect.
- force_relock=1 in any state except PLL_RST: next edge goes to PLL_RST with all domains asserted and all_ready=0. No counter increments. In PLL_RST it is ignored and the hold count is not restarted.
- Priority on the same cycle: force_relock > lock loss > timeout > stability/stage progress.
- Counters saturate at 2^CNT_W-1 and never wrap.
- domain_reset_n is monotonic within one sequence: once a bit is released, it stays high until a loss, force_relock, or reset.

Decomposition:
- Shared defs include (pll_seq_defs.vh): FSM state encodings and the state width constant.
- Sub-module sync_2ff (parametrised width): lock synchroniser, reusable elsewhere in the clocking path.
- FSM, counter, and stage logic stay in pll_reset_sequencer.

Test Plan:
Bench parameters: NUM_DOMAINS=3, PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=3, LOSS_FILTER_CYCLES=2, CNT_W=2.
1. Nominal: release reset; pll_lock rises 5 cycles after pll_resetb rises -> pll_resetb low exactly 4 cycles; domain_reset_n goes 001, 011, 111 at 3-cycle spacing after 8 stable cycles; all_ready 3 cycles after bit 2; both counts 0.
2. Never lock: pll_lock=0 -> pll_resetb low pulse every 36 cycles; retry_count 1, 2, 3, then holds 3 (saturated); domains stay 000.
3. Glitch filter in RUN: pll_lock low 1 cycle -> no change. Low 2 cycles -> domain_reset_n=000, all_ready=0, pll_resetb=0, loss_count=1, state=0.
4. Unstable lock: lock drops after 5 cycles in STABLE -> state=1, no domain released, counts unchanged; then stable lock -> nominal release.
5. force_relock in RELEASE after bit 0 is released -> next edge domain_reset_n=000, state=0, counts unchanged. force_relock coincident with filter expiry -> loss_count unchanged.
6. Async reset asserted mid-RUN between clock edges -> all outputs reach reset values before the next edge; the sequence restarts from PLL_RST on deassertion.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// small elaboration-time helpers.
package pll_reset_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static signals entering the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: drives RESETB, waits for qualified lock with timeout/retry,
// releases domain resets in stages and re-sequences on filtered lock loss.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS         = 2,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int STAGE_GAP_CYCLES    = 16,
    parameter int LOSS_FILTER_CYCLES  = 4,
    parameter int CNT_W               = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_lock,
    input  logic                   force_relock,
    output logic                   pll_resetb,
    output logic [NUM_DOMAINS-1:0] domain_reset_n,
    output logic                   all_ready,
    output logic [CNT_W-1:0]       retry_count,
    output logic [CNT_W-1:0]       loss_count,
    output logic [STATE_W-1:0]     state
);

    // RELEASE also walks the shared counter, so its span sizes the counter too.
    localparam int RELEASE_CYCLES = NUM_DOMAINS * STAGE_GAP_CYCLES;
    localparam int MAX_CYCLES = max_of(max_of(max_of(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES),
                                              max_of(LOCK_STABLE_CYCLES, RELEASE_CYCLES)), 2);
    localparam int CYC_W  = $clog2(MAX_CYCLES);
    localparam int LOSS_W = $clog2(LOSS_FILTER_CYCLES + 1);

    localparam logic [CYC_W-1:0]  PR_LAST  = CYC_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0]  LT_LAST  = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CYC_W-1:0]  LS_LAST  = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0]  REL_LAST = CYC_W'(RELEASE_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LF_LAST  = LOSS_W'(LOSS_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    seq_state_e             state_q, state_d;
    logic [CYC_W-1:0]       cnt_q, cnt_d;
    logic [LOSS_W-1:0]      loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0]       retry_q, retry_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic                   pll_resetb_q, pll_resetb_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   lock_s;
    logic                   loss_hit_s;
    logic [CYC_W:0]         elapsed_s;
    logic [NUM_DOMAINS-1:0] stage_mask_s;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    // Next-state, counters and next output values.
    always_comb begin
        state_d      = state_q;
        retry_d      = retry_q;
        loss_d       = loss_q;
        loss_cnt_d   = '0;
        loss_hit_s   = 1'b0;
        elapsed_s    = '0;
        stage_mask_s = '0;

        if ((state_q == ST_RELEASE) || (state_q == ST_RUN)) begin
            if (!lock_s) begin
                if (loss_cnt_q == LF_LAST) begin
                    loss_hit_s = 1'b1;
                end else begin
                    loss_cnt_d = loss_cnt_q + 1'b1;
                end
            end else begin
                loss_cnt_d = '0;
            end
        end else begin
            loss_cnt_d = '0;
        end

        if (force_relock && (state_q != ST_PLL_RST)) begin
            state_d = ST_PLL_RST;
        end else if (loss_hit_s) begin
            state_d = ST_PLL_RST;
            loss_d  = (loss_q == CNT_MAX) ? loss_q : loss_q + 1'b1;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    state_d = (cnt_q == PR_LAST) ? ST_WAIT_LOCK : ST_PLL_RST;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == LT_LAST) begin
                        state_d = ST_PLL_RST;
                        retry_d = (retry_q == CNT_MAX) ? retry_q : retry_q + 1'b1;
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == LS_LAST) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_STABLE;
                    end
                end
                ST_RELEASE: begin
                    state_d = (cnt_q == REL_LAST) ? ST_RUN : ST_RELEASE;
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_PLL_RST;
                end
            endcase
        end

        if (state_d != state_q) begin
            cnt_d      = '0;
            loss_cnt_d = '0;
        end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end

        // Cycles since the RELEASE entry edge as of the coming edge; 0 on entry.
        if ((state_q == ST_RELEASE) && (state_d == ST_RELEASE)) begin
            elapsed_s = {1'b0, cnt_q} + 1'b1;
        end else begin
            elapsed_s = '0;
        end
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            stage_mask_s[i] = (int'(elapsed_s) >= i * STAGE_GAP_CYCLES);
        end

        pll_resetb_d = (state_d != ST_PLL_RST);
        ready_d      = (state_d == ST_RUN);
        case (state_d)
            ST_RELEASE: dom_d = stage_mask_s;
            ST_RUN:     dom_d = {NUM_DOMAINS{1'b1}};
            default:    dom_d = '0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_PLL_RST;
            cnt_q        <= '0;
            loss_cnt_q   <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            dom_q        <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            dom_q        <= dom_d;
            ready_q      <= ready_d;
        end
    end

    assign pll_resetb     = pll_resetb_q;
    assign domain_reset_n = dom_q;
    assign all_ready      = ready_q;
    assign retry_count    = retry_q;
    assign loss_count     = loss_q;
    assign state          = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer with randomised lock timing; expected
// values come from the sequencing rules expressed as cycle arithmetic.
module tb_pll_reset_sequencer;

    localparam int ND = 3;
    localparam int PR = 4;
    localparam int LT = 32;
    localparam int LS = 8;
    localparam int SG = 3;
    localparam int LF = 2;
    localparam int CW = 2;
    localparam int RETRY_PERIOD = PR + LT;

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_lock;
    logic          force_relock;
    logic          pll_resetb;
    logic [ND-1:0] domain_reset_n;
    logic          all_ready;
    logic [CW-1:0] retry_count;
    logic [CW-1:0] loss_count;
    logic [2:0]    state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .NUM_DOMAINS         (ND),
        .PLL_RESET_CYCLES    (PR),
        .LOCK_TIMEOUT_CYCLES (LT),
        .LOCK_STABLE_CYCLES  (LS),
        .STAGE_GAP_CYCLES    (SG),
        .LOSS_FILTER_CYCLES  (LF),
        .CNT_W               (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pll_lock       (pll_lock),
        .force_relock   (force_relock),
        .pll_resetb     (pll_resetb),
        .domain_reset_n (domain_reset_n),
        .all_ready      (all_ready),
        .retry_count    (retry_count),
        .loss_count     (loss_count),
        .state          (state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (state !== target) begin
            errors++;
            $display("FAIL wait_state: state=%0d required=%0d within %0d cycles", state, target, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; pll_lock = 1'b0; force_relock = 1'b0;
        #12;
        checks++;
        if ({pll_resetb, domain_reset_n, all_ready, retry_count, loss_count, state} !==
            {1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL reset_values: got rb=%b dom=%b rdy=%b rc=%0d lc=%0d st=%0d required 0/000/0/0/0/0",
                     pll_resetb, domain_reset_n, all_ready, retry_count, loss_count, state);
        end
    endtask

    task automatic test_nominal();
        int n;
        int d;
        logic [ND-1:0] exp_dom;
        logic [2:0]    exp_st;
        @(negedge clk); reset = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pll_resetb !== 1'b1 && n < 20);
        checks++;
        if (n != PR || state !== 3'd1) begin
            errors++;
            $display("FAIL nominal_reset_width: low %0d cycles state=%0d required %0d cycles state=1", n, state, PR);
        end
        d = $urandom_range(1, 10);
        repeat (d) tick();
        pll_lock = 1'b1;
        repeat (2) tick();
        checks++;
        if (state !== 3'd1) begin errors++; $display("FAIL nominal_sync_latency: state=%0d required 1", state); end
        tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL nominal_enter_stable: state=%0d required 2", state); end
        repeat (LS - 1) tick();
        checks++;
        if ({state, domain_reset_n} !== {3'd2, 3'b000}) begin
            errors++; $display("FAIL nominal_still_stable: state=%0d dom=%b required 2/000", state, domain_reset_n);
        end
        tick();
        checks++;
        if ({state, domain_reset_n} !== {3'd3, 3'b001}) begin
            errors++; $display("FAIL nominal_release_entry: state=%0d dom=%b required 3/001", state, domain_reset_n);
        end
        for (int k = 1; k <= ND * SG + 2; k++) begin
            tick();
            exp_dom = '0;
            for (int i = 0; i < ND; i++) if (k >= i * SG) exp_dom[i] = 1'b1;
            exp_st = (k >= ND * SG) ? 3'd4 : 3'd3;
            checks++;
            if ({state, domain_reset_n, all_ready} !== {exp_st, exp_dom, (k >= ND * SG)}) begin
                errors++;
                $display("FAIL nominal_stage k=%0d: state=%0d dom=%b rdy=%b required %0d/%b/%b",
                         k, state, domain_reset_n, all_ready, exp_st, exp_dom, (k >= ND * SG));
            end
        end
        checks++;
        if ({pll_resetb, retry_count, loss_count} !== {1'b1, 2'd0, 2'd0}) begin
            errors++; $display("FAIL nominal_counts: rb=%b rc=%0d lc=%0d required 1/0/0", pll_resetb, retry_count, loss_count);
        end
    endtask

    task automatic test_glitch_filter();
        for (int g = 0; g < 3; g++) begin
            repeat ($urandom_range(3, 6)) tick();
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++;
                if ({state, domain_reset_n, all_ready, pll_resetb, loss_count} !== {3'd4, 3'b111, 1'b1, 1'b1, 2'd0}) begin
                    errors++;
                    $display("FAIL glitch_ignored g=%0d c=%0d: st=%0d dom=%b rdy=%b rb=%b lc=%0d required 4/111/1/1/0",
                             g, c, state, domain_reset_n, all_ready, pll_resetb, loss_count);
                end
            end
        end
        repeat (3) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL loss_one_short: state=%0d required 4", state); end
        tick();
        checks++;
        if ({state, domain_reset_n, all_ready, pll_resetb, loss_count, retry_count} !==
            {3'd0, 3'b000, 1'b0, 1'b0, 2'd1, 2'd0}) begin
            errors++;
            $display("FAIL loss_detect: st=%0d dom=%b rdy=%b rb=%b lc=%0d rc=%0d required 0/000/0/0/1/0",
                     state, domain_reset_n, all_ready, pll_resetb, loss_count, retry_count);
        end
    endtask

    task automatic test_unstable_lock();
        int j;
        wait_state(3'd1, PR + 4);
        pll_lock = 1'b1;
        repeat (3) tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL unstable_enter: state=%0d required 2", state); end
        j = $urandom_range(3, LS - 1);
        repeat (j - 3) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL unstable_before_drop j=%0d: state=%0d required 2", j, state); end
        tick();
        checks++;
        if ({state, domain_reset_n, retry_count, loss_count} !== {3'd1, 3'b000, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL unstable_drop j=%0d: st=%0d dom=%b rc=%0d lc=%0d required 1/000/0/1",
                     j, state, domain_reset_n, retry_count, loss_count);
        end
        tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL unstable_relock: state=%0d required 2", state); end
        repeat (LS - 1) tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("FAIL unstable_hold: state=%0d required 2", state); end
        tick();
        checks++;
        if ({state, domain_reset_n} !== {3'd3, 3'b001}) begin
            errors++; $display("FAIL unstable_release: st=%0d dom=%b required 3/001", state, domain_reset_n);
        end
        repeat (ND * SG) tick();
        checks++;
        if ({state, domain_reset_n, all_ready} !== {3'd4, 3'b111, 1'b1}) begin
            errors++; $display("FAIL unstable_run: st=%0d dom=%b rdy=%b required 4/111/1", state, domain_reset_n, all_ready);
        end
    endtask

    task automatic test_force_relock();
        int t;
        force_relock = 1'b1;
        tick();
        checks++;
        if ({state, domain_reset_n, all_ready, pll_resetb, retry_count, loss_count} !==
            {3'd0, 3'b000, 1'b0, 1'b0, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL force_run: st=%0d dom=%b rdy=%b rb=%b rc=%0d lc=%0d required 0/000/0/0/0/1",
                     state, domain_reset_n, all_ready, pll_resetb, retry_count, loss_count);
        end
        repeat (2) tick();
        force_relock = 1'b0;
        tick();
        checks++;
        if ({pll_resetb, state} !== {1'b0, 3'd0}) begin
            errors++; $display("FAIL force_hold_low: rb=%b st=%0d required 0/0", pll_resetb, state);
        end
        tick();
        checks++;
        if ({pll_resetb, state} !== {1'b1, 3'd1}) begin
            errors++; $display("FAIL force_ignored_in_rst: rb=%b st=%0d required 1/1", pll_resetb, state);
        end
        wait_state(3'd3, 40);
        t = $urandom_range(0, 2 * SG + 1);
        repeat (t) tick();
        checks++;
        if ({state, domain_reset_n[0]} !== {3'd3, 1'b1}) begin
            errors++; $display("FAIL force_pre_release t=%0d: st=%0d dom=%b required 3/xx1", t, state, domain_reset_n);
        end
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        checks++;
        if ({state, domain_reset_n, all_ready, retry_count, loss_count} !== {3'd0, 3'b000, 1'b0, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL force_release t=%0d: st=%0d dom=%b rdy=%b rc=%0d lc=%0d required 0/000/0/0/1",
                     t, state, domain_reset_n, all_ready, retry_count, loss_count);
        end
        wait_state(3'd4, 60);
        pll_lock = 1'b0;
        repeat (3) tick();
        checks++;
        if (state !== 3'd4) begin errors++; $display("FAIL force_coincide_pre: state=%0d required 4", state); end
        force_relock = 1'b1;
        tick();
        force_relock = 1'b0;
        pll_lock = 1'b1;
        checks++;
        if ({state, domain_reset_n, all_ready, loss_count} !== {3'd0, 3'b000, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL force_coincide_loss: st=%0d dom=%b rdy=%b lc=%0d required 0/000/0/1",
                     state, domain_reset_n, all_ready, loss_count);
        end
    endtask

    task automatic test_async_reset();
        wait_state(3'd4, 60);
        #2;
        reset = 1'b0;
        pll_lock = 1'b0;
        #1;
        checks++;
        if ({pll_resetb, domain_reset_n, all_ready, retry_count, loss_count, state} !==
            {1'b0, 3'b000, 1'b0, 2'd0, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: rb=%b dom=%b rdy=%b rc=%0d lc=%0d st=%0d required 0/000/0/0/0/0",
                     pll_resetb, domain_reset_n, all_ready, retry_count, loss_count, state);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_never_lock();
        int   m;
        int   exp_rc;
        logic exp_rb;
        for (int n = 1; n <= 4 * RETRY_PERIOD + 4; n++) begin
            tick();
            m      = n % RETRY_PERIOD;
            exp_rb = (m >= PR);
            exp_rc = (n / RETRY_PERIOD > 3) ? 3 : n / RETRY_PERIOD;
            checks++;
            if ({pll_resetb, state, domain_reset_n, retry_count, loss_count} !==
                {exp_rb, (exp_rb ? 3'd1 : 3'd0), 3'b000, 2'(exp_rc), 2'd0}) begin
                errors++;
                $display("FAIL never_lock n=%0d: rb=%b st=%0d dom=%b rc=%0d lc=%0d required %b/%0d/000/%0d/0",
                         n, pll_resetb, state, domain_reset_n, retry_count, loss_count,
                         exp_rb, (exp_rb ? 1 : 0), exp_rc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch_filter();
        test_unstable_lock();
        test_force_relock();
        test_async_reset();
        test_never_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
